// File: rtl/seg_capture.sv
// seg_capture: samples a multiplexed two-digit active-low seven-segment bus,
// waits for a settled pattern and decodes it back to a hex nibble per digit.
module seg_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] an,
    input  logic [6:0] seg,
    input  logic       clr_err,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] valid,
    output logic [1:0] err,
    output logic       update
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    state_t         r_state;
    logic [1:0]     r_an1, r_an2, r_an_p;
    logic [6:0]     r_seg1, r_seg2, r_seg_p;
    logic [CW-1:0]  r_cnt;
    logic [3:0]     r_digit0, r_digit1;
    logic [1:0]     r_valid, r_err;
    logic           r_update;
    logic           w_sel0, w_sel1, w_any, w_chg, w_cap, w_legal, w_blank;
    logic [CW-1:0]  w_nxt;
    logic [3:0]     w_nib;
    logic [1:0]     w_set;
    assign w_sel0  = r_an2 == 2'b10;
    assign w_sel1  = r_an2 == 2'b01;
    assign w_any   = w_sel0 | w_sel1;
    assign w_chg   = {r_an2, r_seg2} != {r_an_p, r_seg_p};
    assign w_blank = r_seg2 == 7'h7F;
    assign w_nxt   = (r_state == SETTLE && !w_chg) ? r_cnt + CW'(1) : CW'(1);
    // an unchanged sample in HOLD never re-captures
    assign w_cap   = w_any && !(r_state == HOLD && !w_chg) && w_nxt == CW'(SETTLE_CYCLES);
    assign w_set   = (w_cap && !w_legal && !w_blank) ? {w_sel1, w_sel0} : 2'b00;
    always_comb begin
        w_legal = 1'b1;
        w_nib   = 4'h0;
        case (r_seg2)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h18: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an1    <= 2'b00;
            r_an2    <= 2'b00;
            r_an_p   <= 2'b00;
            r_seg1   <= 7'h00;
            r_seg2   <= 7'h00;
            r_seg_p  <= 7'h00;
            r_cnt    <= '0;
            r_state  <= IDLE;
            r_digit0 <= 4'h0;
            r_digit1 <= 4'h0;
            r_valid  <= 2'b00;
            r_err    <= 2'b00;
            r_update <= 1'b0;
        end else begin
            r_an1    <= an;
            r_an2    <= r_an1;
            r_an_p   <= r_an2;
            r_seg1   <= seg;
            r_seg2   <= r_seg1;
            r_seg_p  <= r_seg2;
            r_update <= w_cap;
            r_err    <= (r_err & ~{2{clr_err}}) | w_set;
            if (w_cap && w_legal && w_sel0) begin
                r_digit0   <= w_nib;
                r_valid[0] <= 1'b1;
            end
            if (w_cap && w_legal && w_sel1) begin
                r_digit1   <= w_nib;
                r_valid[1] <= 1'b1;
            end
            if (w_cap && w_blank)
                r_valid[w_sel1] <= 1'b0;
            if (!w_any) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (w_cap) begin
                r_state <= HOLD;
                r_cnt   <= w_nxt;
            end else if (!(r_state == HOLD && !w_chg)) begin
                r_state <= SETTLE;
                r_cnt   <= w_nxt;
            end
        end
    end
    assign digit0 = r_digit0;
    assign digit1 = r_digit1;
    assign valid  = r_valid;
    assign err    = r_err;
    assign update = r_update;
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed checks of seg_capture with SETTLE_CYCLES=4.
module tb_seg_capture;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] an = 2'b11;
    logic [6:0] seg = 7'h7F;
    logic       clr_err = 1'b0;
    logic [3:0] digit0, digit1;
    logic [1:0] valid, err;
    logic       update;
    int         n_chk = 0;
    int         n_err = 0;
    int         n_upd = 0;
    int         u0;

    seg_capture #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .clr_err(clr_err),
        .digit0(digit0), .digit1(digit1), .valid(valid), .err(err), .update(update)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (update === 1'b1) n_upd++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_digit0", 32'(digit0), 32'h0);
        chk("rst_digit1", 32'(digit1), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_update", 32'(update), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(2'b11, 7'h7F, 2);
        // 1: first capture latency
        u0 = n_upd;
        drive(2'b10, 7'h24, 5);
        chk("t1_no_early_update", 32'(update), 32'h0);
        @(negedge clk);
        chk("t1_update", 32'(update), 32'h1);
        chk("t1_digit0", 32'(digit0), 32'h2);
        chk("t1_valid", 32'(valid), 32'h1);
        chk("t1_err", 32'(err), 32'h0);
        repeat (4) @(negedge clk);
        chk("t1_one_pulse", 32'(n_upd - u0), 32'd1);
        // 2: alternate digits
        u0 = n_upd;
        drive(2'b10, 7'h79, 8);
        chk("t2_digit0", 32'(digit0), 32'h1);
        drive(2'b01, 7'h0E, 8);
        chk("t2_digit1", 32'(digit1), 32'hF);
        chk("t2_valid", 32'(valid), 32'h3);
        chk("t2_pulses", 32'(n_upd - u0), 32'd2);
        // 3: blank, illegal, clear
        u0 = n_upd;
        drive(2'b01, 7'h7F, 8);
        chk("t3_blank_valid", 32'(valid), 32'h1);
        chk("t3_blank_digit1", 32'(digit1), 32'hF);
        chk("t3_blank_pulse", 32'(n_upd - u0), 32'd1);
        drive(2'b01, 7'h55, 8);
        chk("t3_err", 32'(err), 32'h2);
        chk("t3_err_valid", 32'(valid), 32'h1);
        chk("t3_err_digit1", 32'(digit1), 32'hF);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t3_clr", 32'(err), 32'h0);
        // 4: unstable pattern never captured
        u0 = n_upd;
        for (int i = 0; i < 5; i++) begin
            drive(2'b10, 7'h40, 2);
            drive(2'b10, 7'h79, 2);
        end
        chk("t4_no_update", 32'(n_upd - u0), 32'd0);
        chk("t4_digit0_held", 32'(digit0), 32'h1);
        drive(2'b10, 7'h40, 6);
        chk("t4_digit0", 32'(digit0), 32'h0);
        chk("t4_update", 32'(update), 32'h1);
        // 5: no digit selected, then reset mid-settle
        u0 = n_upd;
        drive(2'b11, 7'h24, 10);
        drive(2'b00, 7'h40, 10);
        chk("t5_no_digit", 32'(n_upd - u0), 32'd0);
        chk("t5_digit1_held", 32'(digit1), 32'hF);
        drive(2'b10, 7'h79, 3);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_digit1", 32'(digit1), 32'h0);
        chk("t5_async_valid", 32'(valid), 32'h0);
        chk("t5_async_digit0", 32'(digit0), 32'h0);
        @(negedge clk);
        an = 2'b11;
        reset = 1'b0;
        u0 = n_upd;
        repeat (10) @(negedge clk);
        chk("t5_no_capture", 32'(n_upd - u0), 32'd0);
        chk("t5_digit0_after", 32'(digit0), 32'h0);
        // 6: capture sets err on the clr_err cycle
        drive(2'b01, 7'h55, 8);
        chk("t6_err1", 32'(err), 32'h2);
        drive(2'b10, 7'h55, 5);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t6_set_wins", 32'(err), 32'h1);
        chk("t6_update", 32'(update), 32'h1);
        chk("t6_valid", 32'(valid), 32'h0);
        repeat (3) @(negedge clk);
        chk("t6_err_sticky", 32'(err), 32'h1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
